// File: rtl/bat_swing_reader_pkg.sv
// ------------------------------------------------------------------------
// bat_swing_reader_pkg: FSM states, run values and LED decode helpers (rev 1.0)
// ------------------------------------------------------------------------
`default_nettype none

package bat_swing_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_JUDGE    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam logic [2:0] RUNS_SIX  = 3'd6;
  localparam logic [2:0] RUNS_FOUR = 3'd4;
  localparam logic [2:0] RUNS_TWO  = 3'd2;
  localparam logic [2:0] RUNS_ONE  = 3'd1;
  localparam logic [2:0] RUNS_DOT  = 3'd0;
  localparam logic [7:0] LED_BLANK = 8'hff;

  typedef struct packed {
    logic       pos_ok;
    logic [2:0] pos;
  } led_decode_t;

  // A valid frame has exactly one dark-driven (0) bit; anything else is a dot ball.
  function automatic led_decode_t decode_led(input logic [7:0] pattern);
    led_decode_t d;
    int          zeros;
    d     = '0;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!pattern[i]) begin
        zeros = zeros + 1;
        d.pos = 3'(i);
      end
    end
    d.pos_ok = (zeros == 1) && (pattern != LED_BLANK);
    if (!d.pos_ok) d.pos = 3'd0;
    return d;
  endfunction

  function automatic logic [2:0] runs_for(input logic [2:0] pos);
    case (pos)
      3'd7:    runs_for = RUNS_SIX;
      3'd6:    runs_for = RUNS_FOUR;
      3'd5:    runs_for = RUNS_TWO;
      3'd4:    runs_for = RUNS_ONE;
      default: runs_for = RUNS_DOT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bat_swing_reader_if.sv
// ------------------------------------------------------------------------
// bat_swing_reader_if: button/LED inputs and judgement/scoreboard outputs (rev 1.0)
// ------------------------------------------------------------------------
`default_nettype none

interface bat_swing_reader_if;
  logic       btn_raw;
  logic [7:0] led;
  logic       swing_valid;
  logic [2:0] hit_pos;
  logic [2:0] runs;
  logic       wicket;
  logic [7:0] score;
  logic [3:0] wickets;
  logic       game_over;

  modport master (
    output btn_raw, led,
    input  swing_valid, hit_pos, runs, wicket, score, wickets, game_over
  );

  modport slave (
    input  btn_raw, led,
    output swing_valid, hit_pos, runs, wicket, score, wickets, game_over
  );
endinterface

`default_nettype wire

// File: rtl/bat_swing_reader_btn_debouncer.sv
// ------------------------------------------------------------------------
// btn_debouncer: 2-FF sync, stability counter and rising-edge press pulse (rev 1.0)
// ------------------------------------------------------------------------
`default_nettype none

module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_fpga,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b00;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn_raw};
      level_q <= level;
      // Any return to the current level discards the partial count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

`default_nettype wire

// File: rtl/bat_swing_reader.sv
// ------------------------------------------------------------------------
// bat_swing_reader: judges debounced bat presses against the LED scroller (rev 1.0)
// ------------------------------------------------------------------------
`default_nettype none

module bat_swing_reader
  import bat_swing_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int MAX_WICKETS     = 10
) (
  input  logic               clk_fpga,
  input  logic               rst_n,
  bat_swing_reader_if.slave  bus
);

  localparam int            CDW     = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]    WKT_MAX = 4'(MAX_WICKETS);

  logic           press;
  logic [7:0]     led_meta;
  logic [7:0]     led_sync;
  state_t         state;
  logic [CDW-1:0] cd_cnt;
  logic           swing_valid_q;
  logic [2:0]     hit_pos_q;
  logic [2:0]     runs_q;
  logic           wicket_q;
  logic [7:0]     score_q;
  logic [3:0]     wickets_q;
  logic           game_over_q;

  led_decode_t    dec;
  logic [2:0]     judged_runs;
  logic           judged_wkt;
  logic [8:0]     score_sum;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_fpga (clk_fpga),
    .rst_n    (rst_n),
    .btn_raw  (bus.btn_raw),
    .press    (press)
  );

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      led_meta <= 8'h00;
      led_sync <= 8'h00;
    end else begin
      led_meta <= bus.led;
      led_sync <= led_meta;
    end
  end

  assign dec         = decode_led(led_sync);
  assign judged_runs = dec.pos_ok ? runs_for(dec.pos) : RUNS_DOT;
  assign judged_wkt  = dec.pos_ok & ~dec.pos[2];
  assign score_sum   = {1'b0, score_q} + {6'd0, judged_runs};

  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cd_cnt        <= '0;
      swing_valid_q <= 1'b0;
      hit_pos_q     <= 3'd0;
      runs_q        <= 3'd0;
      wicket_q      <= 1'b0;
      score_q       <= 8'd0;
      wickets_q     <= 4'd0;
      game_over_q   <= 1'b0;
    end else begin
      swing_valid_q <= 1'b0;
      game_over_q   <= game_over_q | (wickets_q == WKT_MAX);
      case (state)
        ST_IDLE: begin
          if (press && !game_over_q) begin
            state         <= ST_JUDGE;
            swing_valid_q <= 1'b1;
            hit_pos_q     <= dec.pos;
            runs_q        <= judged_runs;
            wicket_q      <= judged_wkt;
            score_q       <= score_sum[8] ? 8'hff : score_sum[7:0];
            if (judged_wkt && (wickets_q < WKT_MAX)) wickets_q <= wickets_q + 4'd1;
          end
        end
        ST_JUDGE: begin
          state  <= ST_COOLDOWN;
          cd_cnt <= '0;
        end
        ST_COOLDOWN: begin
          if (cd_cnt == CD_LAST) state <= ST_IDLE;
          else                   cd_cnt <= cd_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.swing_valid = swing_valid_q;
  assign bus.hit_pos     = hit_pos_q;
  assign bus.runs        = runs_q;
  assign bus.wicket      = wicket_q;
  assign bus.score       = score_q;
  assign bus.wickets     = wickets_q;
  assign bus.game_over   = game_over_q;

endmodule

`default_nettype wire
